// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: one shared rotation stage is reused ITERS times per job, fed from
// an arctan ROM, with valid/ready handshakes on the job input and the result output.

module cordic_engine (
    input  logic [4:0]  i,
    input  logic [31:0] a_i,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic [31:0] w_i,
    input  logic [31:0] theta,
    output logic [31:0] x_n,
    output logic [31:0] y_n,
    output logic [31:0] w_n
);
    logic        rot_pos;
    logic [31:0] x_sh;
    logic [31:0] y_sh;

    // Rotate toward theta; a tie rotates positive so a zero residual still makes progress.
    always_comb begin
        rot_pos = $signed(w_i) <= $signed(theta);
        x_sh    = $signed(x_i) >>> i;
        y_sh    = $signed(y_i) >>> i;
        if (rot_pos) begin
            x_n = x_i - y_sh;
            y_n = y_i + x_sh;
            w_n = w_i + a_i;
        end else begin
            x_n = x_i + y_sh;
            y_n = y_i - x_sh;
            w_n = w_i - a_i;
        end
    end
endmodule

module cordic_iter_ctrl #(
    parameter int unsigned ITERS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] theta_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] w_out,
    output logic        busy
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [4:0] LastIdx = 5'(ITERS - 1);

    // round(atan(2^-i) * 2^30)
    localparam logic [31:0] AtanRom [32] = '{
        32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
        32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
        32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
        32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
        32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
        32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
        32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
        32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
    };

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] w_q, w_d;
    logic [31:0] theta_q, theta_d;
    logic [31:0] x_n, y_n, w_n;

    cordic_engine engine (
        .i    (cnt_q),
        .a_i  (AtanRom[cnt_q]),
        .x_i  (x_q),
        .y_i  (y_q),
        .w_i  (w_q),
        .theta(theta_q),
        .x_n  (x_n),
        .y_n  (y_n),
        .w_n  (w_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            w_q     <= 32'd0;
            theta_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            theta_q <= theta_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (cnt_q == LastIdx) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        theta_d = theta_q;
        if (state_q == StIdle && in_valid) begin
            cnt_d   = 5'd0;
            x_d     = x_in;
            y_d     = y_in;
            w_d     = 32'd0;
            theta_d = theta_in;
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + 5'd1;
            x_d   = x_n;
            y_d   = y_n;
            w_d   = w_n;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StRun);
        out_valid = (state_q == StDone);
        x_out     = x_q;
        y_out     = y_q;
        w_out     = w_q;
    end
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: a 16-iteration instance checked through a result scoreboard, plus
// a 1-iteration instance checked exactly.

module tb_cordic_iter_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] x_in, y_in, theta_in, x_out, y_out, w_out;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [31:0] x_out1, y_out1, w_out1;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] w;
        int          tol;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   job_id = 0;

    localparam logic [32-1:0] InvK   = 32'h26DD3B6A;
    localparam logic [32-1:0] Pi4    = 32'h3243F6A9;
    localparam logic [32-1:0] NegPi4 = 32'hCDBC0957;
    localparam logic [32-1:0] Cos45  = 32'h2D413CCD;
    localparam logic [32-1:0] NegS45 = 32'hD2BEC333;

    always #5 clk = ~clk;

    cordic_iter_ctrl #(.ITERS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .theta_in(theta_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .w_out(w_out), .busy(busy)
    );

    cordic_iter_ctrl #(.ITERS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .x_in(x_in), .y_in(y_in), .theta_in(theta_in),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .x_out(x_out1), .y_out(y_out1), .w_out(w_out1), .busy(busy1)
    );

    // Pops one expected result per handoff on the 16-iteration instance.
    task automatic monitor();
        exp_t e;
        int   dx, dy, dw;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: out_valid handoff x=%h with no job pending",
                             x_out);
                end else begin
                    e  = sb.pop_front();
                    dx = int'($signed(x_out - e.x));
                    dy = int'($signed(y_out - e.y));
                    dw = int'($signed(w_out - e.w));
                    if (dx > e.tol || dx < -e.tol || dy > e.tol || dy < -e.tol ||
                        dw > e.tol || dw < -e.tol) begin
                        errors++;
                        $display("FAIL sb_result job %0d: got x=%h y=%h w=%h, required x=%h y=%h w=%h +/-%h",
                                 e.id, x_out, y_out, w_out, e.x, e.y, e.w, e.tol);
                    end
                end
            end
        end
    endtask

    // Drives one job on the 16-iteration instance; returns at accept edge + 1.
    task automatic drive_job(input logic [31:0] x, input logic [31:0] y, input logic [31:0] t,
                             input bit push, input logic [31:0] ex, input logic [31:0] ey,
                             input logic [31:0] ew, output bit accepted);
        exp_t e;
        accepted = 1'b0;
        @(posedge clk); #1;
        x_in = x; y_in = y; theta_in = t; in_valid = 1'b1;
        if (push) begin
            e.x = ex; e.y = ey; e.w = ew; e.tol = 32'h10000; e.id = job_id;
            sb.push_back(e);
        end
        job_id++;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit acc;
        bit seen;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || x_out !== 32'd0 ||
            y_out !== 32'd0 || w_out !== 32'd0 || x_out1 !== 32'd0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b busy=%b x=%h y=%h w=%h, required 1 0 0 0 0 0",
                     in_ready, out_valid, busy, x_out, y_out, w_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive_job(InvK, 32'd0, Pi4, 1'b0, 32'd0, 32'd0, 32'd0, acc);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || x_out !== 32'd0 ||
            y_out !== 32'd0 || w_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_midrun: ov=%b rdy=%b busy=%b x=%h y=%h w=%h, required 0 1 0 0 0 0",
                     out_valid, in_ready, busy, x_out, y_out, w_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_discard: out_valid seen=1 after mid-run reset, required 0");
        end
    endtask

    task automatic test_pi4();
        bit acc;
        int n;
        drive_job(InvK, 32'd0, Pi4, 1'b1, Cos45, Cos45, Pi4, acc);
        checks++;
        if (!acc || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pi4_accept: acc=%b busy=%b rdy=%b, required 1 1 0", acc, busy, in_ready);
        end
        wait_result(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL pi4_latency: out_valid after %0d cycles, required 16", n);
        end
        handoff();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pi4_release: rdy=%b ov=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero_neg();
        bit acc;
        int n;
        drive_job(InvK, 32'd0, 32'd0, 1'b1, 32'h40000000, 32'd0, 32'd0, acc);
        wait_result(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL zero_latency: out_valid after %0d cycles, required 16", n);
        end
        handoff();
        drive_job(InvK, 32'd0, NegPi4, 1'b1, Cos45, NegS45, NegPi4, acc);
        wait_result(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL neg_latency: out_valid after %0d cycles, required 16", n);
        end
        handoff();
    endtask

    task automatic test_backpressure();
        bit          acc;
        int          n;
        logic [31:0] sx, sy, sw;
        drive_job(InvK, 32'd0, Pi4, 1'b1, Cos45, Cos45, Pi4, acc);
        wait_result(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL bp_latency: out_valid after %0d cycles, required 16", n);
        end
        sx = x_out; sy = y_out; sw = w_out;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            checks++;
            if (x_out !== sx || y_out !== sy || w_out !== sw || out_valid !== 1'b1 ||
                in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: x=%h y=%h w=%h ov=%b rdy=%b, required %h %h %h 1 0",
                         k, x_out, y_out, w_out, out_valid, in_ready, sx, sy, sw);
            end
        end
        handoff();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: rdy=%b ov=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   acc_cyc[2];
        int   n_acc;
        int   cyc;
        out_ready = 1'b1;
        @(posedge clk); #1;
        x_in = InvK; y_in = 32'd0; theta_in = 32'd0; in_valid = 1'b1;
        e.x = 32'h40000000; e.y = 32'd0; e.w = 32'd0; e.tol = 32'h10000; e.id = job_id++;
        sb.push_back(e);
        n_acc = 0;
        cyc = 0;
        for (int k = 0; k < 80 && n_acc < 2; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    @(posedge clk); #1;
                    cyc++;
                    theta_in = NegPi4;
                    e.x = Cos45; e.y = NegS45; e.w = NegPi4; e.id = job_id++;
                    sb.push_back(e);
                    continue;
                end
                @(posedge clk); #1;
                cyc++;
                in_valid = 1'b0;
                continue;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (n_acc != 2 || acc_cyc[1] - acc_cyc[0] != 18) begin
            errors++;
            $display("FAIL b2b_period: accepts=%0d spacing=%0d, required 2 and 18",
                     n_acc, acc_cyc[1] - acc_cyc[0]);
        end
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d results outstanding, required 0", sb.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_iters1();
        @(posedge clk); #1;
        x_in = 32'h40000000; y_in = 32'd0; theta_in = 32'd0; in_valid1 = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL it1_ready: rdy=%b, required 1", in_ready1);
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL it1_run: ov=%b busy=%b, required 0 1", out_valid1, busy1);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid1 !== 1'b1 || x_out1 !== 32'h40000000 || y_out1 !== 32'h40000000 ||
            w_out1 !== Pi4) begin
            errors++;
            $display("FAIL it1_result: ov=%b x=%h y=%h w=%h, required 1 40000000 40000000 %h",
                     out_valid1, x_out1, y_out1, w_out1, Pi4);
        end
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL it1_release: rdy=%b ov=%b, required 1 0", in_ready1, out_valid1);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        x_in = '0; y_in = '0; theta_in = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_pi4();
        test_zero_neg();
        test_backpressure();
        test_back_to_back();
        test_iters1();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_final: %0d results never produced, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cordic_iter_ctrl.md
# cordic_iter_ctrl

Iterative CORDIC sequencer: accepts one (x0, y0, theta) job over a valid/ready handshake and drives a single internal `engine` rotation stage for ITERS consecutive cycles. It supplies the shift index and arctangent constant from an internal ROM and feeds the engine's outputs back into its inputs each cycle. It then holds the result until the consumer accepts it. It sits between the fixed-point front end and downstream consumers, and replaces an unrolled ITERS-stage pipeline with one shared stage.

## Interface
- ITERS, 16, number of micro-rotations per job; legal range 1..32 (engine index is 5 bits)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  job present on x_in/y_in/theta_in
- in_ready  out  1  controller can accept a job
- x_in  in  32  signed initial x, Q2.30
- y_in  in  32  signed initial y, Q2.30
- theta_in  in  32  target angle, radians, Q2.30, range [-pi/2, +pi/2]
- out_valid  out  1  result present on x_out/y_out/w_out
- out_ready  in  1  consumer accepts result
- x_out  out  32  signed final x, Q2.30, gain K≈1.64676 not compensated
- y_out  out  32  signed final y, Q2.30
- w_out  out  32  final accumulated angle, Q2.30
- busy  out  1  high in RUN

## Operation
- Contains one `engine` instance, a 32-entry arctan ROM, registers x_r/y_r/w_r/theta_r, a 5-bit iteration counter cnt, and a state register.
- ROM entry i = round(atan(2^-i)·2^30). Entry 0 = 0x3243F6A9, entry 1 = 0x1DAC6705. Entries beyond ITERS-1 are unused.
- Engine hookup: i=cnt, a_i=ROM[cnt], x_i=x_r, y_i=y_r, w_i=w_r, theta=theta_r. x_n/y_n/w_n are the next-state values in RUN.
- States:
  - IDLE: in_ready=1. On in_valid: x_r←x_in, y_r←y_in, w_r←0, theta_r←theta_in, cnt←0, go to RUN.
  - RUN: each cycle x_r/y_r/w_r←engine outputs and cnt←cnt+1. When cnt==ITERS-1, this final update completes and the state goes to DONE.
  - DONE: out_valid=1. x_out/y_out/w_out = x_r/y_r/w_r and are held stable. On out_ready, go to IDLE.
- Data registers change only on IDLE accept or in RUN. Arithmetic wraps at 32 bits, with no saturation.
- Jobs are strictly serial: in_ready=0 in RUN and DONE. A new job is not accepted in the same cycle the previous result is accepted.
- theta_in outside [-pi/2, +pi/2] produces an unconverged result. This is not flagged.

## Timing
- Reset (asynchronous assert, synchronous to clk on release): state=IDLE, cnt=0, all data registers 0.
  - Outputs during and after reset: in_ready=1, out_valid=0, busy=0, x_out=y_out=w_out=0.
- Accept at edge E0 (in_valid & in_ready).
- RUN occupies edges E1..E_ITERS. out_valid rises after edge E_ITERS, i.e. ITERS cycles after accept.
- Result handoff is at the edge where out_valid & out_ready. in_ready=1 from the next cycle. Minimum job-to-job period is ITERS+2 cycles.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; the producer must hold it.
- ITERS=1: one RUN cycle (cnt 0 only), then DONE.
- Reset asserted mid-RUN or in DONE: immediate return to reset state. The job is discarded with no out_valid pulse.

## Test plan
- Reset: assert rst mid-run at cycle 5 of a job -> out_valid=0 and in_ready=1 immediately, x_out=y_out=w_out=0; no out_valid ever appears for that job.
- pi/4 vector: x_in=0x26DD3B6A (1/K), y_in=0, theta_in=0x3243F6A9 -> out_valid exactly 16 cycles after accept; x_out and y_out each within ±0x10000 of 0x2D413CCD; w_out within ±0x10000 of theta_in.
- Zero/negative angle: x_in=0x26DD3B6A, theta_in=0 -> x_out≈0x40000000, y_out≈0 (±0x10000). Repeat with theta_in=0xCDBC0957 (−pi/4) -> y_out≈0xD2BEC333.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0, out_valid stays high; release -> in_ready=1 the cycle after handoff.
- Back-to-back: in_valid held high with two jobs, out_ready tied 1 -> second accept occurs exactly ITERS+2 cycles after the first; both results match the single-job golden values.
- ITERS=1 build: x_in=0x40000000, y_in=0, theta_in=0 -> out_valid 1 cycle after accept; x_out=0x40000000, y_out=0x40000000, w_out=0x3243F6A9.
